muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execute unit that sits directly downstream of the register file.
- Consumes the registered rs1/rs2 operands and the funct3 op from decode.
- Produces one XLEN-bit result, tagged with rd, for the writeback port.
- Uses a single shared shift/add datapath and a valid/ready handshake on both sides.

Parameters:
XLEN, 32, operand/result width; only 32 is verified
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
i_valid  input  1  request valid
o_ready  output  1  unit can accept a request (high only in IDLE)
i_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
i_src1  input  XLEN  rs1 operand (multiplicand/dividend)
i_src2  input  XLEN  rs2 operand (multiplier/divisor)
i_rd  input  5  destination register tag
i_flush  input  1  abort the in-flight operation
o_valid  output  1  result valid
i_ready  input  1  consumer accepts result
o_result  output  XLEN  result
o_rd  output  5  destination tag of the result

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; counter is cleared.
  - o_valid=0, o_ready=1 once in IDLE, o_result=0, o_rd=0.
  - Asserting rst mid-CALC or in DONE discards the operation; no o_valid follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - Accept on posedge with i_valid && o_ready.
  - On accept, latch op, rd, operands and the sign flags. MULH/DIV/REM treat both operands as signed; MULHSU treats src1 signed and src2 unsigned; the others are unsigned.
  - Convert operands to magnitudes; record the result sign.
- Special cases, decided at accept and going straight to DONE (o_valid high after 1 edge):
  - DIV/DIVU with src2==0: quotient 0xFFFFFFFF.
  - REM/REMU with src2==0: result = src1.
  - DIV with src1=0x80000000 and src2=0xFFFFFFFF: result 0x80000000.
  - REM with the same operands: result 0.
- Otherwise go to CALC with counter=XLEN.
- CALC, one iteration per cycle, XLEN cycles, counter decrements:
  - Multiply: 2*XLEN product register, shift-add on the LSB of the multiplier.
  - Divide: restoring divide on a 2*XLEN remainder/quotient register.
  - At counter==1 the edge enters DONE with the sign-corrected result registered.
- Latency: o_valid rises XLEN+1 posedges after the accept edge (33 for XLEN=32).
- Result selection:
  - MUL returns the low XLEN product bits; MULH/MULHSU/MULHU return the high XLEN bits after two's-complement negation of the full 2*XLEN product when the sign is negative.
  - DIV/DIVU return the quotient, negated when the operand signs differ (DIV only).
  - REM/REMU return the remainder with the sign of the dividend (REM only).
- DONE:
  - o_valid=1; o_result and o_rd are held stable until i_ready.
  - On an o_valid && i_ready edge, return to IDLE. No same-cycle re-accept: o_ready is low in DONE.
- i_flush:
  - In CALC or DONE, the next edge returns to IDLE with o_valid=0.
  - In IDLE, the flush has priority over i_valid; no accept occurs.
- Ignored inputs: i_src*/i_op/i_rd are don't-care outside the accept cycle.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_e enum of the 8 funct3 encodings;
  - state_e {IDLE, CALC, DONE};
  - helper functions is_div(op), is_signed_src1(op), is_signed_src2(op), wants_high(op).
- One sub-module, muldiv_core: the shared iteration datapath (magnitude registers, 2*XLEN accumulator, one step per enable).
- The top level holds the FSM, handshake and sign fix-up.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> o_result 0xFFFFFFEB, o_rd echoed, o_valid exactly 33 edges after accept.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, both after 1 edge; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIVU 100/7 -> 14, REMU -> 2.
- Hold i_ready=0 for 10 cycles in DONE -> o_valid and o_result stable, o_ready=0 throughout; i_valid pulses meanwhile are ignored.
- Assert rst asynchronously at CALC cycle 10 -> o_valid=0 immediately, o_ready=1; i_flush at CALC cycle 5 -> IDLE next edge, no result; the next request completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned RD_W     = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_src1(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_src2(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic wants_high(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bus between decode, the muldiv unit and writeback.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  import muldiv_pkg::*;

  logic               i_valid;
  logic               o_ready;
  muldiv_op_e         i_op;
  logic [XLEN-1:0]    i_src1;
  logic [XLEN-1:0]    i_src2;
  logic [RD_W-1:0]    i_rd;
  logic               i_flush;
  logic               o_valid;
  logic               i_ready;
  logic [XLEN-1:0]    o_result;
  logic [RD_W-1:0]    o_rd;

  modport slave (
    input  i_valid, i_op, i_src1, i_src2, i_rd, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rd
  );

  modport master (
    output i_valid, i_op, i_src1, i_src2, i_rd, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_rd
  );

endinterface

// File: rtl/muldiv_core.sv
// Shared shift/add datapath: one multiply (shift-add) or restoring-divide step per enable.
module muldiv_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] acc_nxt_c
);

  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic              div_q;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;

  // Multiply: {hi,lo} with multiplier in lo; divide: {remainder, quotient}
  always_comb begin
    sum       = '0;
    rem_sh    = '0;
    diff      = '0;
    acc_nxt_c = acc_q;
    if (div_q) begin
      rem_sh = acc_q[2*XLEN-1:XLEN-1];
      diff   = rem_sh - {1'b0, b_q};
      if (!diff[XLEN]) begin
        acc_nxt_c = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt_c = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      sum       = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : (XLEN+1)'(0));
      acc_nxt_c = {sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc_q <= {{XLEN{1'b0}}, a_mag};
      b_q   <= b_mag;
      div_q <= div_mode;
    end else if (step) begin
      acc_q <= acc_nxt_c;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide execute unit: FSM, handshake, special cases and sign fix-up.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  muldiv_op_e        op_q;
  logic              neg_q;
  logic              valid_q;
  logic              ready_q;
  logic [XLEN-1:0]   result_q;
  logic [RD_W-1:0]   rd_q;

  logic              accept_c;
  logic              s1_neg_c, s2_neg_c, neg_c;
  logic [XLEN-1:0]   a_mag_c, b_mag_c;
  logic              special_c;
  logic [XLEN-1:0]   special_res_c;
  logic [2*XLEN-1:0] acc_nxt_c;
  logic [2*XLEN-1:0] prod_fix_c;
  logic [XLEN-1:0]   div_sel_c;
  logic [XLEN-1:0]   fixed_res_c;

  assign accept_c = (state_q == IDLE) && bus.i_valid && !bus.i_flush;

  // Operand magnitudes, result sign and the divide corner cases decided at accept
  always_comb begin
    s1_neg_c      = is_signed_src1(bus.i_op) && bus.i_src1[XLEN-1];
    s2_neg_c      = is_signed_src2(bus.i_op) && bus.i_src2[XLEN-1];
    a_mag_c       = s1_neg_c ? XLEN'(-bus.i_src1) : bus.i_src1;
    b_mag_c       = s2_neg_c ? XLEN'(-bus.i_src2) : bus.i_src2;
    neg_c         = is_rem(bus.i_op) ? s1_neg_c : (s1_neg_c ^ s2_neg_c);
    special_c     = 1'b0;
    special_res_c = '0;
    if (is_div(bus.i_op) && (bus.i_src2 == '0)) begin
      special_c     = 1'b1;
      special_res_c = is_rem(bus.i_op) ? bus.i_src1 : {XLEN{1'b1}};
    end else if (((bus.i_op == OP_DIV) || (bus.i_op == OP_REM)) &&
                 (bus.i_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.i_src2 == {XLEN{1'b1}})) begin
      special_c     = 1'b1;
      special_res_c = is_rem(bus.i_op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept_c && !special_c),
    .step      (state_q == CALC),
    .div_mode  (is_div(bus.i_op)),
    .a_mag     (a_mag_c),
    .b_mag     (b_mag_c),
    .acc_nxt_c (acc_nxt_c)
  );

  // Sign correction applied to the final iteration's accumulator
  always_comb begin
    prod_fix_c  = neg_q ? (2*XLEN)'(-acc_nxt_c) : acc_nxt_c;
    div_sel_c   = is_rem(op_q) ? acc_nxt_c[2*XLEN-1:XLEN] : acc_nxt_c[XLEN-1:0];
    fixed_res_c = '0;
    if (is_div(op_q)) begin
      fixed_res_c = neg_q ? XLEN'(-div_sel_c) : div_sel_c;
    end else begin
      fixed_res_c = wants_high(op_q) ? prod_fix_c[2*XLEN-1:XLEN] : prod_fix_c[XLEN-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept_c) state_d = special_c ? DONE : CALC;
      CALC: begin
        if (bus.i_flush)                 state_d = IDLE;
        else if (cnt_q == CNT_W'(1))     state_d = DONE;
      end
      DONE: if (bus.i_flush || bus.i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == DONE);
      ready_q <= (state_d == IDLE);
      if (accept_c) begin
        op_q  <= bus.i_op;
        neg_q <= neg_c;
        rd_q  <= bus.i_rd;
        cnt_q <= CNT_W'(XLEN);
        if (special_c) result_q <= special_res_c;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (state_d == DONE) result_q <= fixed_res_c;
      end
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_ready  = ready_q;
  assign bus.o_result = result_q;
  assign bus.o_rd     = rd_q;

endmodule
